// File: rtl/munoc_axi4_wid_tracker_pkg.sv
// Shared widths and sizing helpers for the AXI4-to-AXI3 WID tracker.
// The AXI field widths mirror the platform's AXI define set.
package munoc_axi4_wid_tracker_pkg;

  localparam int DEFAULT_BW_AXI_TID = 4;
  localparam int BW_AXI_ALEN        = 8;
  localparam int BW_AXI_ASIZE       = 3;
  localparam int BW_AXI_ABURST      = 2;

  function automatic int bw_axi_wstrb(input int bw_data);
    return bw_data / 8;
  endfunction

  // One FIFO entry holds {awid, awlen}.
  function automatic int wid_entry_width(input int bw_tid);
    return bw_tid + BW_AXI_ALEN;
  endfunction

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/munoc_wid_fifo.sv
// Generic synchronous FIFO with registered count and extra-MSB pointers
// so full and empty are distinguishable without a separate flag.
module munoc_wid_fifo
  import munoc_axi4_wid_tracker_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rstnn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head_data = mem_q[rd_ptr_q[PW-1:0]];
  assign count     = count_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rstnn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/munoc_axi4_wid_tracker.sv
// Generates AXI3 WID for an AXI4 master by queueing {awid, awlen} per AW
// and stamping each W beat with the oldest unfinished burst's ID.
module munoc_axi4_wid_tracker
  import munoc_axi4_wid_tracker_pkg::*;
#(
  parameter  int BW_AXI_TID       = DEFAULT_BW_AXI_TID,
  parameter  int BW_PLATFORM_ADDR = 32,
  parameter  int BW_NODE_DATA     = 32,
  parameter  int NUM_OUTSTANDING  = 4,
  parameter  bit LEN_CHECK        = 1'b1,
  parameter  bit FORCE_LAST       = 1'b0,
  localparam int BW_STRB          = bw_axi_wstrb(BW_NODE_DATA),
  localparam int BW_CNT           = count_width(NUM_OUTSTANDING)
) (
  input  logic                        clk,
  input  logic                        rstnn,
  input  logic [BW_AXI_TID-1:0]       rx4awid,
  input  logic [BW_PLATFORM_ADDR-1:0] rx4awaddr,
  input  logic [BW_AXI_ALEN-1:0]      rx4awlen,
  input  logic [BW_AXI_ASIZE-1:0]     rx4awsize,
  input  logic [BW_AXI_ABURST-1:0]    rx4awburst,
  input  logic                        rx4awvalid,
  output logic                        rx4awready,
  input  logic [BW_NODE_DATA-1:0]     rx4wdata,
  input  logic [BW_STRB-1:0]          rx4wstrb,
  input  logic                        rx4wlast,
  input  logic                        rx4wvalid,
  output logic                        rx4wready,
  output logic [BW_AXI_TID-1:0]       txawid,
  output logic [BW_PLATFORM_ADDR-1:0] txawaddr,
  output logic [BW_AXI_ALEN-1:0]      txawlen,
  output logic [BW_AXI_ASIZE-1:0]     txawsize,
  output logic [BW_AXI_ABURST-1:0]    txawburst,
  output logic                        txawvalid,
  input  logic                        txawready,
  output logic [BW_AXI_TID-1:0]       txwid,
  output logic [BW_NODE_DATA-1:0]     txwdata,
  output logic [BW_STRB-1:0]          txwstrb,
  output logic                        txwlast,
  output logic                        txwvalid,
  input  logic                        txwready,
  output logic [BW_CNT-1:0]           outstanding_count,
  output logic                        wlast_error,
  input  logic                        clear_error
);

  localparam int BW_ENTRY = wid_entry_width(BW_AXI_TID);

  logic                   fifo_full, fifo_empty;
  logic [BW_ENTRY-1:0]    head_entry;
  logic [BW_AXI_TID-1:0]  head_id;
  logic [BW_AXI_ALEN-1:0] head_len;
  logic                   aw_hs, w_hs, beat_is_last, pop;
  logic [BW_AXI_ALEN-1:0] beat_cnt_q, beat_cnt_d;
  logic                   wlast_error_q, wlast_error_d;

  assign txawid    = rx4awid;
  assign txawaddr  = rx4awaddr;
  assign txawlen   = rx4awlen;
  assign txawsize  = rx4awsize;
  assign txawburst = rx4awburst;
  assign txwdata   = rx4wdata;
  assign txwstrb   = rx4wstrb;

  // Handshake outputs are forced low while in reset, not just after it.
  assign txawvalid  = rstnn & rx4awvalid & ~fifo_full;
  assign rx4awready = rstnn & txawready  & ~fifo_full;
  assign txwvalid   = rstnn & rx4wvalid  & ~fifo_empty;
  assign rx4wready  = rstnn & txwready   & ~fifo_empty;

  assign aw_hs = txawvalid & txawready;
  assign w_hs  = txwvalid & txwready;

  assign {head_id, head_len} = head_entry;
  assign txwid        = head_id;
  assign beat_is_last = (beat_cnt_q == head_len);

  // Pop on the earlier of WLAST and the AWLEN-implied last beat so the ID stream stays aligned.
  assign pop     = w_hs & (rx4wlast | (LEN_CHECK & beat_is_last));
  assign txwlast = (FORCE_LAST && LEN_CHECK) ? beat_is_last : rx4wlast;

  assign wlast_error = wlast_error_q;

  always_comb begin
    beat_cnt_d    = beat_cnt_q;
    wlast_error_d = wlast_error_q;
    if (LEN_CHECK) begin
      if (pop)       beat_cnt_d = '0;
      else if (w_hs) beat_cnt_d = beat_cnt_q + 1'b1;
      if (clear_error) wlast_error_d = 1'b0;
      if (w_hs && (rx4wlast != beat_is_last)) wlast_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      beat_cnt_q    <= '0;
      wlast_error_q <= 1'b0;
    end else begin
      beat_cnt_q    <= beat_cnt_d;
      wlast_error_q <= wlast_error_d;
    end
  end

  munoc_wid_fifo #(
    .WIDTH (BW_ENTRY),
    .DEPTH (NUM_OUTSTANDING)
  ) u_fifo (
    .clk       (clk),
    .rstnn     (rstnn),
    .push      (aw_hs),
    .pop       (pop),
    .push_data ({rx4awid, rx4awlen}),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding_count)
  );

endmodule

// File: tb/tb_munoc_axi4_wid_tracker.sv
// Scenario bench for the WID tracker: directed cases plus a randomized run
// against a queue-based model; a FORCE_LAST instance shares the stimulus.
module tb_munoc_axi4_wid_tracker;
  import munoc_axi4_wid_tracker_pkg::*;

  localparam int TID  = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = 4;
  localparam int NOUT = 4;
  localparam int CW   = 3;
  localparam int LW   = BW_AXI_ALEN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstnn;
  logic [TID-1:0] aw_id;
  logic [AW-1:0]  aw_addr;
  logic [LW-1:0]  aw_len;
  logic [2:0]     aw_size;
  logic [1:0]     aw_burst;
  logic           aw_valid;
  logic [DW-1:0]  w_data;
  logic [SW-1:0]  w_strb;
  logic           w_last, w_valid, tx_awready, tx_wready, clear_err;

  logic           rx4awready, txawvalid, rx4wready, txwvalid, txwlast, wlast_error;
  logic [TID-1:0] txawid, txwid;
  logic [AW-1:0]  txawaddr;
  logic [LW-1:0]  txawlen;
  logic [2:0]     txawsize;
  logic [1:0]     txawburst;
  logic [DW-1:0]  txwdata;
  logic [SW-1:0]  txwstrb;
  logic [CW-1:0]  outstanding_count;

  logic           f_rx4awready, f_txawvalid, f_rx4wready, f_txwvalid, f_txwlast, f_wlast_error;
  logic [TID-1:0] f_txawid, f_txwid;
  logic [AW-1:0]  f_txawaddr;
  logic [LW-1:0]  f_txawlen;
  logic [2:0]     f_txawsize;
  logic [1:0]     f_txawburst;
  logic [DW-1:0]  f_txwdata;
  logic [SW-1:0]  f_txwstrb;
  logic [CW-1:0]  f_outstanding_count;

  munoc_axi4_wid_tracker dut (
    .clk(clk), .rstnn(rstnn),
    .rx4awid(aw_id), .rx4awaddr(aw_addr), .rx4awlen(aw_len), .rx4awsize(aw_size),
    .rx4awburst(aw_burst), .rx4awvalid(aw_valid), .rx4awready(rx4awready),
    .rx4wdata(w_data), .rx4wstrb(w_strb), .rx4wlast(w_last), .rx4wvalid(w_valid),
    .rx4wready(rx4wready),
    .txawid(txawid), .txawaddr(txawaddr), .txawlen(txawlen), .txawsize(txawsize),
    .txawburst(txawburst), .txawvalid(txawvalid), .txawready(tx_awready),
    .txwid(txwid), .txwdata(txwdata), .txwstrb(txwstrb), .txwlast(txwlast),
    .txwvalid(txwvalid), .txwready(tx_wready),
    .outstanding_count(outstanding_count), .wlast_error(wlast_error), .clear_error(clear_err)
  );

  munoc_axi4_wid_tracker #(.FORCE_LAST(1'b1)) dut_fl (
    .clk(clk), .rstnn(rstnn),
    .rx4awid(aw_id), .rx4awaddr(aw_addr), .rx4awlen(aw_len), .rx4awsize(aw_size),
    .rx4awburst(aw_burst), .rx4awvalid(aw_valid), .rx4awready(f_rx4awready),
    .rx4wdata(w_data), .rx4wstrb(w_strb), .rx4wlast(w_last), .rx4wvalid(w_valid),
    .rx4wready(f_rx4wready),
    .txawid(f_txawid), .txawaddr(f_txawaddr), .txawlen(f_txawlen), .txawsize(f_txawsize),
    .txawburst(f_txawburst), .txawvalid(f_txawvalid), .txawready(tx_awready),
    .txwid(f_txwid), .txwdata(f_txwdata), .txwstrb(f_txwstrb), .txwlast(f_txwlast),
    .txwvalid(f_txwvalid), .txwready(tx_wready),
    .outstanding_count(f_outstanding_count), .wlast_error(f_wlast_error), .clear_error(clear_err)
  );

  // Reference model: queue of outstanding bursts plus beats already sent of the head burst.
  typedef struct { int unsigned id; int unsigned len; } burst_t;
  burst_t      m_q[$];
  int unsigned m_beats;
  bit          m_err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic           e_awready, e_awvalid, e_wready, e_wvalid, e_err, e_empty, e_f_txwlast;
  logic [TID-1:0] e_wid;
  logic [CW-1:0]  e_count;
  logic           o_awready, o_awvalid, o_wready, o_wvalid, o_err, o_txwlast, o_f_txwlast;
  logic [TID-1:0] o_wid, o_awid;
  logic [DW-1:0]  o_wdata;
  logic [CW-1:0]  o_count;

  task automatic drive(input logic awv, input logic [TID-1:0] id, input logic [LW-1:0] len,
                       input logic wv, input logic wl);
    aw_valid   = awv;
    aw_id      = id;
    aw_len     = len;
    aw_addr    = $urandom;
    aw_size    = 3'd2;
    aw_burst   = 2'd1;
    w_valid    = wv;
    w_last     = wl;
    w_data     = $urandom;
    w_strb     = 4'hf;
    tx_awready = 1'b1;
    tx_wready  = 1'b1;
    clear_err  = 1'b0;
  endtask

  // Samples the DUT mid-cycle, records model expectations, then advances the model.
  task automatic step();
    bit     is_last, w_hs, aw_hs;
    burst_t b;
    @(negedge clk);
    if (!rstnn) begin
      m_q.delete();
      m_beats = 0;
      m_err   = 1'b0;
    end
    e_empty     = (m_q.size() == 0);
    is_last     = !e_empty && (m_beats == m_q[0].len);
    e_awvalid   = rstnn && aw_valid && (m_q.size() < NOUT);
    e_awready   = rstnn && tx_awready && (m_q.size() < NOUT);
    e_wvalid    = rstnn && w_valid && !e_empty;
    e_wready    = rstnn && tx_wready && !e_empty;
    e_wid       = e_empty ? '0 : TID'(m_q[0].id);
    e_count     = CW'(m_q.size());
    e_err       = m_err;
    e_f_txwlast = is_last;
    o_awready   = rx4awready;
    o_awvalid   = txawvalid;
    o_wready    = rx4wready;
    o_wvalid    = txwvalid;
    o_err       = wlast_error;
    o_txwlast   = txwlast;
    o_f_txwlast = f_txwlast;
    o_wid       = txwid;
    o_awid      = txawid;
    o_wdata     = txwdata;
    o_count     = outstanding_count;
    if (rstnn) begin
      w_hs  = e_wvalid && tx_wready;
      aw_hs = e_awvalid && tx_awready;
      if (w_hs && (w_last != is_last)) m_err = 1'b1;
      else if (clear_err)              m_err = 1'b0;
      if (w_hs) begin
        if (w_last || is_last) begin
          void'(m_q.pop_front());
          m_beats = 0;
        end else begin
          m_beats++;
        end
      end
      if (aw_hs) begin
        b.id  = aw_id;
        b.len = aw_len;
        m_q.push_back(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstnn = 1'b1;
    drive(1'b1, 4'd5, 8'd2, 1'b1, 1'b1);
    #1 rstnn = 1'b0;
    step();
    tests_run++; if (o_awready !== 1'b0) begin tests_failed++; $display("FAIL reset_awready: got %b expected 0", o_awready); end
    tests_run++; if (o_awvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_awvalid: got %b expected 0", o_awvalid); end
    tests_run++; if (o_wready !== 1'b0) begin tests_failed++; $display("FAIL reset_wready: got %b expected 0", o_wready); end
    tests_run++; if (o_wvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_wvalid: got %b expected 0", o_wvalid); end
    tests_run++; if (o_count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", o_count); end
    tests_run++; if (o_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", o_err); end
    rstnn = 1'b1;
    drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_single_burst();
    drive(1'b1, 4'd3, 8'd3, 1'b0, 1'b0);
    step();
    tests_run++; if (o_awready !== 1'b1) begin tests_failed++; $display("FAIL single_awready: got %b expected 1", o_awready); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'd0, 8'd0, 1'b1, i == 3);
      step();
      tests_run++; if (o_wid !== 4'd3) begin tests_failed++; $display("FAIL single_wid beat %0d: got %0d expected 3", i, o_wid); end
      tests_run++; if (o_count !== 3'd1) begin tests_failed++; $display("FAIL single_count beat %0d: got %0d expected 1", i, o_count); end
    end
    drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    step();
    tests_run++; if (o_count !== 3'd0) begin tests_failed++; $display("FAIL single_count_after: got %0d expected 0", o_count); end
    tests_run++; if (o_err !== 1'b0) begin tests_failed++; $display("FAIL single_err: got %b expected 0", o_err); end
  endtask

  task automatic test_interleaved();
    logic [TID-1:0] ids[3]   = '{4'd1, 4'd2, 4'd5};
    logic [LW-1:0]  lens[3]  = '{8'd0, 8'd1, 8'd2};
    logic [TID-1:0] wids[6]  = '{4'd1, 4'd2, 4'd2, 4'd5, 4'd5, 4'd5};
    logic           lasts[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ids[i], lens[i], 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 4'd0, 8'd0, 1'b1, lasts[i]);
      step();
      if (i == 0) begin
        tests_run++; if (o_count !== 3'd3) begin tests_failed++; $display("FAIL inter_count_peak: got %0d expected 3", o_count); end
      end
      tests_run++; if (o_wid !== wids[i]) begin tests_failed++; $display("FAIL inter_wid beat %0d: got %0d expected %0d", i, o_wid, wids[i]); end
    end
    drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    step();
    tests_run++; if (o_count !== 3'd0) begin tests_failed++; $display("FAIL inter_count_after: got %0d expected 0", o_count); end
    tests_run++; if (o_err !== 1'b0) begin tests_failed++; $display("FAIL inter_err: got %b expected 0", o_err); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, TID'(8 + i), 8'd0, 1'b0, 1'b0);
      step();
      tests_run++; if (o_awready !== 1'b1) begin tests_failed++; $display("FAIL full_fill_awready %0d: got %b expected 1", i, o_awready); end
    end
    drive(1'b1, 4'd12, 8'd0, 1'b0, 1'b0);
    step();
    tests_run++; if (o_awready !== 1'b0) begin tests_failed++; $display("FAIL full_blocked: got %b expected 0", o_awready); end
    tests_run++; if (o_count !== 3'd4) begin tests_failed++; $display("FAIL full_count: got %0d expected 4", o_count); end
    drive(1'b1, 4'd12, 8'd0, 1'b1, 1'b1);
    step();
    tests_run++; if (o_awready !== 1'b0) begin tests_failed++; $display("FAIL full_pop_cycle_awready: got %b expected 0", o_awready); end
    tests_run++; if (o_wid !== 4'd8) begin tests_failed++; $display("FAIL full_pop_wid: got %0d expected 8", o_wid); end
    drive(1'b1, 4'd12, 8'd0, 1'b0, 1'b0);
    step();
    tests_run++; if (o_awready !== 1'b1) begin tests_failed++; $display("FAIL full_after_pop_awready: got %b expected 1", o_awready); end
    tests_run++; if (o_count !== 3'd3) begin tests_failed++; $display("FAIL full_after_pop_count: got %0d expected 3", o_count); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'd0, 8'd0, 1'b1, 1'b1);
      step();
      tests_run++; if (o_wid !== TID'(9 + i)) begin tests_failed++; $display("FAIL full_drain_wid %0d: got %0d expected %0d", i, o_wid, 9 + i); end
    end
    drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    step();
    tests_run++; if (o_count !== 3'd0) begin tests_failed++; $display("FAIL full_drained_count: got %0d expected 0", o_count); end
  endtask

  task automatic test_early_wlast();
    drive(1'b1, 4'd6, 8'd3, 1'b0, 1'b0); step();
    drive(1'b1, 4'd2, 8'd0, 1'b0, 1'b0); step();
    drive(1'b0, 4'd0, 8'd0, 1'b1, 1'b0); step();
    tests_run++; if (o_wid !== 4'd6) begin tests_failed++; $display("FAIL early_wid0: got %0d expected 6", o_wid); end
    drive(1'b0, 4'd0, 8'd0, 1'b1, 1'b1); step();
    tests_run++; if (o_err !== 1'b0) begin tests_failed++; $display("FAIL early_err_before: got %b expected 0", o_err); end
    tests_run++; if (o_f_txwlast !== 1'b0) begin tests_failed++; $display("FAIL early_forced_last: got %b expected 0", o_f_txwlast); end
    drive(1'b0, 4'd0, 8'd0, 1'b1, 1'b1); step();
    tests_run++; if (o_err !== 1'b1) begin tests_failed++; $display("FAIL early_err_set: got %b expected 1", o_err); end
    tests_run++; if (o_wid !== 4'd2) begin tests_failed++; $display("FAIL early_next_wid: got %0d expected 2", o_wid); end
    drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b0); clear_err = 1'b1; step();
    tests_run++; if (o_count !== 3'd0) begin tests_failed++; $display("FAIL early_count: got %0d expected 0", o_count); end
    drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b0); step();
    tests_run++; if (o_err !== 1'b0) begin tests_failed++; $display("FAIL early_err_cleared: got %b expected 0", o_err); end
  endtask

  task automatic test_force_last();
    drive(1'b1, 4'd4, 8'd1, 1'b0, 1'b0); step();
    drive(1'b0, 4'd0, 8'd0, 1'b1, 1'b0); step();
    tests_run++; if (o_f_txwlast !== 1'b0) begin tests_failed++; $display("FAIL force_beat1_last: got %b expected 0", o_f_txwlast); end
    drive(1'b0, 4'd0, 8'd0, 1'b1, 1'b0); clear_err = 1'b1; step();
    tests_run++; if (o_f_txwlast !== 1'b1) begin tests_failed++; $display("FAIL force_beat2_last: got %b expected 1", o_f_txwlast); end
    tests_run++; if (o_txwlast !== 1'b0) begin tests_failed++; $display("FAIL force_passthru_last: got %b expected 0", o_txwlast); end
    tests_run++; if (o_wid !== 4'd4) begin tests_failed++; $display("FAIL force_wid: got %0d expected 4", o_wid); end
    drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b0); step();
    tests_run++; if (o_count !== 3'd0) begin tests_failed++; $display("FAIL force_popped: got %0d expected 0", o_count); end
    tests_run++; if (o_err !== 1'b1) begin tests_failed++; $display("FAIL force_err_set_over_clear: got %b expected 1", o_err); end
    drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b0); clear_err = 1'b1; step();
    drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b0); step();
    tests_run++; if (o_err !== 1'b0) begin tests_failed++; $display("FAIL force_err_cleared: got %b expected 0", o_err); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'd1, 8'd3, 1'b0, 1'b0); step();
    drive(1'b1, 4'd2, 8'd1, 1'b0, 1'b0); step();
    drive(1'b0, 4'd0, 8'd0, 1'b1, 1'b0); step();
    rstnn = 1'b0;
    drive(1'b1, 4'd3, 8'd0, 1'b1, 1'b1); step();
    tests_run++; if ({o_awready, o_awvalid, o_wready, o_wvalid} !== 4'b0000) begin tests_failed++; $display("FAIL midreset_handshakes: got %b expected 0000", {o_awready, o_awvalid, o_wready, o_wvalid}); end
    tests_run++; if (o_count !== 3'd0) begin tests_failed++; $display("FAIL midreset_count: got %0d expected 0", o_count); end
    rstnn = 1'b1;
    drive(1'b1, 4'd7, 8'd0, 1'b0, 1'b0); step();
    drive(1'b0, 4'd0, 8'd0, 1'b1, 1'b1); step();
    tests_run++; if (o_wid !== 4'd7) begin tests_failed++; $display("FAIL midreset_new_wid: got %0d expected 7", o_wid); end
    tests_run++; if (o_count !== 3'd1) begin tests_failed++; $display("FAIL midreset_new_count: got %0d expected 1", o_count); end
    drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b0); step();
  endtask

  task automatic test_random();
    bit exp_last;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1) == 1, TID'($urandom), LW'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, 1'b0);
      tx_awready = $urandom_range(0, 3) != 0;
      tx_wready  = $urandom_range(0, 3) != 0;
      clear_err  = $urandom_range(0, 15) == 0;
      exp_last   = (m_q.size() > 0) && (m_beats == m_q[0].len);
      w_last     = ($urandom_range(0, 7) == 0) ? !exp_last : exp_last;
      step();
      tests_run++; if (o_awready !== e_awready) begin tests_failed++; $display("FAIL rand_awready @%0d: got %b expected %b", n, o_awready, e_awready); end
      tests_run++; if (o_awvalid !== e_awvalid) begin tests_failed++; $display("FAIL rand_awvalid @%0d: got %b expected %b", n, o_awvalid, e_awvalid); end
      tests_run++; if (o_wready !== e_wready) begin tests_failed++; $display("FAIL rand_wready @%0d: got %b expected %b", n, o_wready, e_wready); end
      tests_run++; if (o_wvalid !== e_wvalid) begin tests_failed++; $display("FAIL rand_wvalid @%0d: got %b expected %b", n, o_wvalid, e_wvalid); end
      tests_run++; if (o_count !== e_count) begin tests_failed++; $display("FAIL rand_count @%0d: got %0d expected %0d", n, o_count, e_count); end
      tests_run++; if (o_err !== e_err) begin tests_failed++; $display("FAIL rand_err @%0d: got %b expected %b", n, o_err, e_err); end
      tests_run++; if (o_awid !== aw_id) begin tests_failed++; $display("FAIL rand_awid @%0d: got %0d expected %0d", n, o_awid, aw_id); end
      tests_run++; if (o_wdata !== w_data) begin tests_failed++; $display("FAIL rand_wdata @%0d: got %h expected %h", n, o_wdata, w_data); end
      tests_run++; if (o_txwlast !== w_last) begin tests_failed++; $display("FAIL rand_txwlast @%0d: got %b expected %b", n, o_txwlast, w_last); end
      if (!e_empty) begin
        tests_run++; if (o_wid !== e_wid) begin tests_failed++; $display("FAIL rand_wid @%0d: got %0d expected %0d", n, o_wid, e_wid); end
        tests_run++; if (o_f_txwlast !== e_f_txwlast) begin tests_failed++; $display("FAIL rand_forced_last @%0d: got %b expected %b", n, o_f_txwlast, e_f_txwlast); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    m_beats = 0;
    m_err   = 1'b0;
    test_reset();
    test_single_burst();
    test_interleaved();
    test_full();
    test_early_wlast();
    test_force_last();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
